// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers; times each frame itself.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int CLKS_PER_BIT  = 5208,
  parameter int FRAME_BITS    = 12,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                   clk_50M,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_write,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  localparam logic [23:0] STROBE_LAST = 24'(STROBE_CYCLES - 1);
  localparam logic [23:0] WAIT_LAST   = 24'(FRAME_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [23:0]         count_reg, count_next;
  logic [ID_W-1:0]     last_reg, last_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [7:0]          data_reg, data_next;
  logic                write_reg, write_next;
  logic                busy_reg, busy_next;
  logic [NUM_REQ-1:0]  ready_reg, ready_next;

  logic [7:0]          byte_arr [NUM_REQ];
  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign byte_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Later loop iterations overwrite earlier ones, so the search runs from the lowest priority upward.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'(i);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_reg) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    write_next = write_reg;
    busy_next  = busy_reg;
    ready_next = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          ready_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          data_next  = byte_arr[winner];
          grant_next = winner;
          last_next  = winner;
          write_next = 1'b1;
          busy_next  = 1'b1;
          count_next = '0;
          state_next = STROBE;
        end
      end
      STROBE: begin
        count_next = count_reg + 24'd1;
        if (count_reg == STROBE_LAST) begin
          write_next = 1'b0;
          count_next = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        count_next = count_reg + 24'd1;
        if (count_reg == WAIT_LAST) begin
          busy_next  = 1'b0;
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      last_reg  <= ID_W'(NUM_REQ - 1);
      grant_reg <= '0;
      data_reg  <= '0;
      write_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ready_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      data_reg  <= data_next;
      write_reg <= write_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
    end
  end

  assign req_ready = ready_reg;
  assign tx_data   = data_reg;
  assign tx_write  = write_reg;
  assign busy      = busy_reg;
  assign grant_id  = grant_reg;

endmodule
